load_store_unit: RTL
====================

# load_store_unit

Memory-access initiator between the pipeline's MEM stage and the word-wide `Data_Memory` block. It accepts RV32 load/store requests of byte, half or word size over a valid/ready handshake and converts them into word-aligned `MemRead`/`MemWrite` cycles. Sub-word stores are done as read-modify-write. Load data is returned sign- or zero-extended, and misaligned, illegal or out-of-range requests are flagged.

## Interface
Parameters:
- MEM_BYTES, 128: memory size in bytes; any byte address at or above this is out of range.

Ports:
- clk_i  in  1  clock; everything is sampled on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit idle and able to accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RV32 funct3 (size/sign).
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_rdata_o  out  32  extended load data; 0 for stores.
- resp_err_o  out  1  misaligned, illegal funct3 or out of range; valid with resp_valid_o.
- mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_data_o  out  32  write word.
- mem_read_o  out  1  MemRead.
- mem_write_o  out  1  MemWrite; the memory commits it at the next rising edge.
- mem_data_i  in  32  read word; combinational from memory while mem_read_o=1.

## Operation
- Handshake: a request is accepted when req_valid_i & req_ready_o. Request fields are registered on acceptance.
- One request is in flight at a time. req_ready_o=1 only in IDLE.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW.
- Error conditions:
  - Any other funct3.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - addr+size > MEM_BYTES.
- Errored requests go IDLE→RESP with resp_err_o=1 and rdata=0. No memory strobe is issued.
- States:
  - IDLE: on accept, go to ERR-path RESP, LOAD (loads), WRITE (SW) or RMW_RD (SB/SH).
  - LOAD: mem_read_o=1. The byte/half lane selected by addr[1:0] is extracted from mem_data_i, extended, registered, then →RESP.
  - RMW_RD: mem_read_o=1. The word is captured with the store byte/half merged into its lane, then →WRITE.
  - WRITE: mem_write_o=1, mem_data_o = merged word (SW: req_wdata), then →RESP.
  - RESP: resp_valid_o=1, then →IDLE.
- Responses have no back-pressure. The consumer must take resp in the cycle it is shown.
- Sign extension replicates bit 7 (LB) or bit 15 (LH). LBU/LHU zero-fill.
- Strobes and mem_data_o are 0 outside the states that drive them. mem_addr_o holds the registered aligned address.

## Timing
- Request accepted at edge T:
  - LW/LB/LH/LBU/LHU: LOAD in T+1, resp_valid_o in T+2.
  - SW: WRITE in T+1, resp in T+2.
  - SB/SH: RMW_RD T+1, WRITE T+2, resp T+3.
  - Error: resp in T+1.
- Back-to-back: a new request can be accepted in the cycle after RESP (IDLE), so throughput is 1 per 3 cycles for LW/SW.
- Reset values: state IDLE; req_ready_o=1; resp_valid_o, resp_err_o, resp_rdata_o, mem_read_o, mem_write_o, mem_data_o, mem_addr_o all 0.
- Reset mid-operation: the next state is IDLE and no response is issued. mem_write_o and mem_read_o are gated by ~rst_i, so a store in WRITE while rst_i=1 is not committed.
- req_valid_i while not ready is ignored. It is not queued, and the requester must hold it.

## Structure
- Package lsu_pkg: state enum (IDLE, LOAD, RMW_RD, WRITE, RESP), funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), and a size-decode function.
- Sub-module lsu_align (combinational): load lane extract/extend and store lane merge from funct3, addr[1:0], the word and wdata. The FSM and registers stay in load_store_unit.

## Test plan
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → memory word 4 = 0xDEADBEEF; resp at T+2 with rdata 0xDEADBEEF, err=0.
- Preload word 0x20 = 0x11223344. SB addr 0x22 data 0xAB → word becomes 0x11AB3344; mem_write_o high in T+2 only; resp at T+3.
- Word 0x30 = 0x8000F0FF. LB 0x30 → 0xFFFFFFFF; LBU 0x30 → 0x000000FF; LH 0x32 → 0xFFFF8000; LHU 0x32 → 0x00008000.
- LW 0x13, SH 0x21, LB 0x80, funct3 011 → each gives resp at T+1 with err=1 and no mem_read_o or mem_write_o pulse.
- Assert rst_i in the WRITE cycle of SW 0x40 data 0x5 → word 0x40 is unchanged, no resp_valid_o, req_ready_o=1 on the first cycle after reset.
- Hold req_valid_i high during a load in flight → only one response, and the second request is accepted in IDLE after RESP.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size in bytes; the low two funct3 bits carry the size for both loads and stores.
    function automatic logic [2:0] lsu_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic lsu_f3_legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/half lane steering: load extract with sign/zero extension, and store lane merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_word,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_load_data,
    output logic [XLEN-1:0] o_store_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_load_data = i_word;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_HU:   o_load_data = {16'd0, w_half};
            default: o_load_data = i_word;
        endcase
    end

    // Store data arrives right-aligned; place it in the lane picked by the low address bits.
    always_comb begin
        o_store_word = i_word;
        case (i_funct3)
            F3_B: begin
                case (i_addr_lo)
                    2'd0:    o_store_word[7:0]   = i_wdata[7:0];
                    2'd1:    o_store_word[15:8]  = i_wdata[7:0];
                    2'd2:    o_store_word[23:16] = i_wdata[7:0];
                    default: o_store_word[31:24] = i_wdata[7:0];
                endcase
            end
            F3_H: begin
                if (i_addr_lo[1]) begin
                    o_store_word[31:16] = i_wdata[15:0];
                end else begin
                    o_store_word[15:0] = i_wdata[15:0];
                end
            end
            default: o_store_word = i_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: one request at a time, word-aligned memory cycles,
// read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            resp_valid_o,
    output logic [XLEN-1:0] resp_rdata_o,
    output logic            resp_err_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_data_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    input  logic [XLEN-1:0] mem_data_i
);

    lsu_state_t r_state;
    lsu_state_t w_next_state;

    logic [2:0]      r_funct3;
    logic [1:0]      r_addr_lo;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rdata;
    logic            r_err;

    logic            w_accept;
    logic [2:0]      w_size;
    logic [XLEN:0]   w_end;
    logic            w_misaligned;
    logic            w_req_err;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_store_word;

    assign w_accept = req_valid_i && (r_state == IDLE);
    assign w_size   = lsu_size(req_funct3_i);

    // One bit wider so an address near 2^32 cannot wrap back into range.
    assign w_end        = {1'b0, req_addr_i} + (XLEN+1)'(w_size);
    assign w_misaligned = ((w_size == 3'd2) && req_addr_i[0]) ||
                          ((w_size == 3'd4) && (req_addr_i[1:0] != 2'b00));
    assign w_req_err    = !lsu_f3_legal(req_we_i, req_funct3_i) || w_misaligned ||
                          (w_end > (XLEN+1)'(MEM_BYTES));

    lsu_align u_align (
        .i_funct3     (r_funct3),
        .i_addr_lo    (r_addr_lo),
        .i_word       (mem_data_i),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_err_o   = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_data_o   = '0;
        case (r_state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (w_accept) begin
                    if (w_req_err) begin
                        w_next_state = RESP;
                    end else if (!req_we_i) begin
                        w_next_state = LOAD;
                    end else if (req_funct3_i == F3_W) begin
                        w_next_state = WRITE;
                    end else begin
                        w_next_state = RMW_RD;
                    end
                end
            end
            LOAD: begin
                mem_read_o   = !rst_i;
                w_next_state = RESP;
            end
            RMW_RD: begin
                mem_read_o   = !rst_i;
                w_next_state = WRITE;
            end
            WRITE: begin
                mem_write_o  = !rst_i;
                mem_data_o   = r_wdata;
                w_next_state = RESP;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                resp_err_o   = r_err;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Request capture, load result and merged store word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_funct3  <= '0;
            r_addr_lo <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_funct3  <= req_funct3_i;
            r_addr_lo <= req_addr_i[1:0];
            r_addr    <= {req_addr_i[XLEN-1:2], 2'b00};
            r_wdata   <= req_wdata_i;
            r_rdata   <= '0;
            r_err     <= w_req_err;
        end else if (r_state == LOAD) begin
            r_rdata <= w_load_data;
        end else if (r_state == RMW_RD) begin
            r_wdata <= w_store_word;
        end
    end

    assign resp_rdata_o = r_rdata;
    assign mem_addr_o   = r_addr;

endmodule
